// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one 2:1 datapath mux between requesters A and B; optional per-side stats under MUX2_ARB_STATS_EN.
// Latency: a request seen in IDLE is granted on the next edge; datapath (out_data/out_valid/ready_x) is combinational from the grant.
// Backpressure: out_ready=0 holds the current grant indefinitely; the burst limit counts accepted beats only.
module mux2_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    output logic             ready_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    output logic             ready_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel,
    output logic             gnt_a,
    output logic             gnt_b
`ifdef MUX2_ARB_STATS_EN
    ,
    output logic [15:0]      cnt_a,
    output logic [15:0]      cnt_b,
    output logic             contended
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GA   = 2'b01,
        GB   = 2'b10
    } state_t;

    localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

    state_t     state_q, state_d;
    logic       last_a_q, last_a_d;
    logic [3:0] beat_cnt_q, beat_cnt_d;
    logic       beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_a_q   <= 1'b0;
            beat_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            last_a_q   <= last_a_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_a_d   = last_a_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                // On contention, the side that did not hold the last grant wins.
                if (req_a && (!req_b || !last_a_q)) begin
                    state_d    = GA;
                    last_a_d   = 1'b1;
                    beat_cnt_d = 4'd0;
                end else if (req_b) begin
                    state_d    = GB;
                    last_a_d   = 1'b0;
                    beat_cnt_d = 4'd0;
                end
            end
            GA: begin
                if (!req_a || (beat && beat_cnt_q == LAST_BEAT)) begin
                    beat_cnt_d = 4'd0;
                    if (req_b) begin
                        state_d  = GB;
                        last_a_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (beat) begin
                    beat_cnt_d = beat_cnt_q + 4'd1;
                end
            end
            GB: begin
                if (!req_b || (beat && beat_cnt_q == LAST_BEAT)) begin
                    beat_cnt_d = 4'd0;
                    if (req_a) begin
                        state_d  = GA;
                        last_a_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (beat) begin
                    beat_cnt_d = beat_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d    = IDLE;
                beat_cnt_d = 4'd0;
            end
        endcase
    end

    // Grants and select decode straight from the state register, so they only move on an edge.
    always_comb begin
        gnt_a = (state_q == GA);
        gnt_b = (state_q == GB);
        sel   = (state_q == GA);
    end

    assign out_data  = sel ? data_a : data_b;
    assign out_valid = (gnt_a & req_a) | (gnt_b & req_b);
    assign ready_a   = gnt_a & out_ready;
    assign ready_b   = gnt_b & out_ready;
    assign beat      = out_valid & out_ready;

`ifdef MUX2_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_a     <= 16'd0;
            cnt_b     <= 16'd0;
            contended <= 1'b0;
        end else begin
            if (beat && gnt_a && cnt_a != 16'hFFFF) cnt_a <= cnt_a + 16'd1;
            if (beat && gnt_b && cnt_b != 16'hFFFF) cnt_b <= cnt_b + 16'd1;
            contended <= (state_q == IDLE) && req_a && req_b;
        end
    end
`endif

endmodule
